// File: rtl/computer_pkg.sv
// Shared types for the unified memory path of the 4-bit computer.
// Bus controller states and requester select.
package computer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } bus_state_t;

  typedef enum logic {
    SEL_INSTR,
    SEL_DATA
  } port_sel_t;

  function automatic int unsigned tmr_width(
    input int unsigned lat
  );
    return (lat < 1) ? 1 : $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/mem_bus_ctrl_if.sv
// CPU fetch/data ports, stall reporting and memory port bundle.
// slave: controller view; master: CPU and memory view.
interface mem_bus_ctrl_if #(
  parameter int DWIDTH = 8,
  parameter int IWIDTH = 16,
  parameter int COUNTW = 16
);

  logic              i_req;
  logic [DWIDTH-1:0] i_addr;
  logic              i_ack;
  logic [IWIDTH-1:0] i_rdata;

  logic              d_req;
  logic              d_we;
  logic [DWIDTH-1:0] d_addr;
  logic [DWIDTH-1:0] d_wdata;
  logic              d_ack;
  logic [DWIDTH-1:0] d_rdata;

  logic              stall;
  logic              stall_clr;
  logic [COUNTW-1:0] stall_cnt;

  logic              mem_en;
  logic              mem_we;
  logic [DWIDTH-1:0] mem_addr;
  logic [DWIDTH-1:0] mem_wdata;
  logic [IWIDTH-1:0] mem_rdata;

  modport slave (
    input  i_req, i_addr,
    input  d_req, d_we, d_addr, d_wdata,
    input  stall_clr, mem_rdata,
    output i_ack, i_rdata,
    output d_ack, d_rdata,
    output stall, stall_cnt,
    output mem_en, mem_we,
    output mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr,
    output d_req, d_we, d_addr, d_wdata,
    output stall_clr, mem_rdata,
    input  i_ack, i_rdata,
    input  d_ack, d_rdata,
    input  stall, stall_cnt,
    input  mem_en, mem_we,
    input  mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_bus_ctrl_timer.sv
// Loadable down-counter that flags when the memory
// response is due; holds at zero once expired.
module mem_lat_timer #(
  parameter int LATENCY = 2,
  parameter int TW      = $clog2(LATENCY + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic done
);

  localparam logic [TW-1:0] LOADV = TW'(LATENCY);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOADV;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/mem_bus_ctrl.sv
// Shared single-port memory controller: fetch/data arbitration,
// fixed-latency access sequencing and stall-cycle accounting.
module mem_bus_ctrl
  import computer_pkg::*;
#(
  parameter int DWIDTH  = 8,
  parameter int IWIDTH  = 16,
  parameter int LATENCY = 2,
  parameter int COUNTW  = 16
) (
  input logic           clk,
  input logic           reset,
  mem_bus_ctrl_if.slave bus
);

  localparam int TW = tmr_width(LATENCY);

  bus_state_t        state;
  port_sel_t         sel;
  logic              is_st;
  logic              i_ack_q;
  logic              d_ack_q;
  logic [IWIDTH-1:0] i_rdata_q;
  logic [DWIDTH-1:0] d_rdata_q;
  logic              mem_en_q;
  logic              mem_we_q;
  logic [DWIDTH-1:0] mem_addr_q;
  logic [DWIDTH-1:0] mem_wdata_q;
  logic [COUNTW-1:0] cnt_q;

  logic tmr_load;
  logic tmr_dec;
  logic tmr_done;
  logic stall;

  assign tmr_load = (state == IDLE)
                  & (bus.d_req | bus.i_req);
  assign tmr_dec  = (state == BUSY);

  mem_lat_timer #(
    .LATENCY(LATENCY),
    .TW     (TW)
  ) u_tmr (
    .clk  (clk),
    .rst_n(reset),
    .load (tmr_load),
    .dec  (tmr_dec),
    .done (tmr_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      sel         <= SEL_INSTR;
      is_st       <= 1'b0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      unique case (state)
        IDLE: begin
          // data port wins any tie with fetch
          if (bus.d_req) begin
            state       <= BUSY;
            sel         <= SEL_DATA;
            is_st       <= bus.d_we;
            mem_en_q    <= 1'b1;
            mem_we_q    <= bus.d_we;
            mem_addr_q  <= bus.d_addr;
            mem_wdata_q <= bus.d_wdata;
          end else if (bus.i_req) begin
            state       <= BUSY;
            sel         <= SEL_INSTR;
            is_st       <= 1'b0;
            mem_en_q    <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= bus.i_addr;
            mem_wdata_q <= '0;
          end
        end
        BUSY: begin
          if (tmr_done) begin
            state <= RESP;
            if (sel == SEL_DATA) begin
              d_ack_q <= 1'b1;
              if (!is_st) begin
                d_rdata_q <= bus.mem_rdata[DWIDTH-1:0];
              end
            end else begin
              i_ack_q   <= 1'b1;
              i_rdata_q <= bus.mem_rdata;
            end
          end
        end
        RESP: begin
          i_ack_q <= 1'b0;
          d_ack_q <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // held low while reset is asserted so every output reads 0
  assign stall = reset
               & ((bus.i_req & ~i_ack_q)
               |  (bus.d_req & ~d_ack_q));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (bus.stall_clr) begin
      cnt_q <= '0;
    end else if (stall && cnt_q != '1) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.i_ack     = i_ack_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.stall     = stall;
  assign bus.stall_cnt = cnt_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Bench for mem_bus_ctrl: transaction-timeline model, directed
// scenarios with literal expectations, then randomized traffic.
module tb_mem_bus_ctrl;

  localparam int DW = 8;
  localparam int IW = 16;
  localparam int L  = 2;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_bus_ctrl_if #(.DWIDTH(DW), .IWIDTH(IW),
    .COUNTW(CW)) bif ();
  mem_bus_ctrl_if #(.DWIDTH(DW), .IWIDTH(IW),
    .COUNTW(16)) bif1 ();

  mem_bus_ctrl #(.DWIDTH(DW), .IWIDTH(IW),
    .LATENCY(L), .COUNTW(CW)) dut (
    .clk(clk), .reset(reset), .bus(bif));

  mem_bus_ctrl #(.DWIDTH(DW), .IWIDTH(IW),
    .LATENCY(1), .COUNTW(16)) dut1 (
    .clk(clk), .reset(reset), .bus(bif1));

  logic [15:0] mem [256];

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  bit rnd  = 0;

  // staged inputs for the next cycle
  logic n_reset, n_ireq, n_dreq, n_dwe, n_clr;
  logic [7:0] n_iaddr, n_daddr, n_dwdata;
  logic n1_ireq;
  logic [7:0] n1_iaddr;

  // model: at most one access in flight
  bit act;
  int t0;
  bit tsel;
  bit twe;
  logic [7:0] taddr, twd;
  logic [15:0] e_ird;
  logic [7:0] e_drd;
  int e_cnt;
  bit e_stall, e_men, e_ia, e_da;
  bit pa_i, pa_d;

  int dq[$];
  logic [15:0] vq[$];
  int dq1[$];
  logic [15:0] vq1[$];

  task automatic chk(input string nm,
                     input logic [31:0] a,
                     input logic [31:0] e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s cyc=%0d got=%h want=%h",
               nm, cyc, a, e);
    end
  endtask

  task automatic model_step();
    if (!reset) begin
      act   = 0;
      e_ird = '0;
      e_drd = '0;
      e_cnt = 0;
    end else begin
      if (bif.stall_clr) e_cnt = 0;
      else if (e_stall && e_cnt < (1 << CW) - 1)
        e_cnt++;
      if (act && cyc == t0 + 1 + L) begin
        if (!tsel) e_ird = mem[taddr];
        else if (!twe) e_drd = mem[taddr][7:0];
      end
      if (act && cyc == t0 + 2 + L) begin
        act = 0;
      end else if (!act && bif.d_req) begin
        act = 1; t0 = cyc; tsel = 1;
        twe = bif.d_we; taddr = bif.d_addr;
        twd = bif.d_wdata;
      end else if (!act && bif.i_req) begin
        act = 1; t0 = cyc; tsel = 0;
        twe = 0; taddr = bif.i_addr; twd = '0;
      end
    end
    cyc++;
  endtask

  task automatic gen();
    reset = ($urandom_range(0, 299) != 0);
    if (!(bif.i_req && !pa_i)) begin
      bif.i_req  = ($urandom_range(0, 3) != 0);
      bif.i_addr = 8'($urandom);
    end
    if (!(bif.d_req && !pa_d)) begin
      bif.d_req   = ($urandom_range(0, 2) == 0);
      bif.d_we    = 1'($urandom);
      bif.d_addr  = 8'($urandom);
      bif.d_wdata = 8'($urandom);
    end
    bif.stall_clr = ($urandom_range(0, 31) == 0);
  endtask

  task automatic compare();
    bit r;
    r = (reset === 1'b1);
    e_men = r && act && (cyc == t0 + 1);
    e_ia  = r && act && !tsel && (cyc == t0 + 2 + L);
    e_da  = r && act && tsel && (cyc == t0 + 2 + L);
    e_stall = r && ((bif.i_req && !e_ia)
                 || (bif.d_req && !e_da));
    chk("i_ack", bif.i_ack, e_ia);
    chk("d_ack", bif.d_ack, e_da);
    chk("mem_en", bif.mem_en, e_men);
    chk("stall", bif.stall, e_stall);
    chk("stall_cnt", bif.stall_cnt, r ? e_cnt : 0);
    chk("i_rdata", bif.i_rdata, r ? e_ird : 16'h0);
    chk("d_rdata", bif.d_rdata, r ? e_drd : 8'h0);
    if (e_men) begin
      chk("mem_we", bif.mem_we, twe);
      chk("mem_addr", bif.mem_addr, taddr);
      chk("mem_wdata", bif.mem_wdata, twd);
    end
    if (!r) begin
      chk("rst_we", bif.mem_we, 0);
      chk("rst_addr", bif.mem_addr, 0);
      chk("rst_wdata", bif.mem_wdata, 0);
    end
    pa_i = e_ia;
    pa_d = e_da;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    if (rnd) begin
      gen();
    end else begin
      reset         = n_reset;
      bif.i_req     = n_ireq;
      bif.i_addr    = n_iaddr;
      bif.d_req     = n_dreq;
      bif.d_we      = n_dwe;
      bif.d_addr    = n_daddr;
      bif.d_wdata   = n_dwdata;
      bif.stall_clr = n_clr;
    end
    bif1.i_req  = n1_ireq;
    bif1.i_addr = n1_iaddr;
    while (dq.size() > 0 && dq[0] < cyc) begin
      void'(dq.pop_front()); void'(vq.pop_front());
    end
    if (dq.size() > 0 && dq[0] == cyc) begin
      void'(dq.pop_front());
      bif.mem_rdata = vq.pop_front();
    end else begin
      bif.mem_rdata = 16'($urandom);
    end
    while (dq1.size() > 0 && dq1[0] < cyc) begin
      void'(dq1.pop_front()); void'(vq1.pop_front());
    end
    if (dq1.size() > 0 && dq1[0] == cyc) begin
      void'(dq1.pop_front());
      bif1.mem_rdata = vq1.pop_front();
    end else begin
      bif1.mem_rdata = 16'($urandom);
    end
    @(negedge clk);
    compare();
    if (bif.mem_en === 1'b1) begin
      dq.push_back(cyc + L);
      vq.push_back(mem[bif.mem_addr]);
    end
    if (bif1.mem_en === 1'b1) begin
      dq1.push_back(cyc + 1);
      vq1.push_back(mem[bif1.mem_addr]);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[8'h10] = 16'h00A5;
    mem[8'h11] = 16'h0077;
    mem[8'h30] = 16'h1234;
    mem[8'h50] = 16'hBEEF;
    mem[8'h51] = 16'h0F0F;
    mem[8'h52] = 16'hC001;
    mem[8'h41] = 16'h5A66;
    bif.i_req = 0; bif.i_addr = 0; bif.d_req = 0;
    bif.d_we = 0; bif.d_addr = 0; bif.d_wdata = 0;
    bif.stall_clr = 0; bif.mem_rdata = 0;
    bif1.i_req = 0; bif1.i_addr = 0; bif1.d_req = 0;
    bif1.d_we = 0; bif1.d_addr = 0; bif1.d_wdata = 0;
    bif1.stall_clr = 0; bif1.mem_rdata = 0;
    n_reset = 0; n_ireq = 0; n_dreq = 0; n_dwe = 0;
    n_clr = 0; n_iaddr = 0; n_daddr = 0; n_dwdata = 0;
    n1_ireq = 0; n1_iaddr = 0;
    act = 0; t0 = 0; tsel = 0; twe = 0;
    taddr = 0; twd = 0; e_ird = 0; e_drd = 0;
    e_cnt = 0; e_stall = 0; pa_i = 0; pa_d = 0;

    repeat (3) step();
    chk("rst_mem_en", bif.mem_en, 0);
    chk("rst_i_ack", bif.i_ack, 0);
    chk("rst_d_ack", bif.d_ack, 0);
    chk("rst_cnt", bif.stall_cnt, 0);
    chk("rst_i_rdata", bif.i_rdata, 0);
    chk("rst_d_rdata", bif.d_rdata, 0);
    n_reset = 1;
    step();

    // LATENCY=1 fetch stream with a new address after each ack
    n1_ireq = 1; n1_iaddr = 8'h50;
    for (int k = 0; k < 12; k++) begin
      step();
      chk("t4_i_ack", bif1.i_ack,
          (k == 3 || k == 7 || k == 11));
      chk("t4_mem_en", bif1.mem_en,
          (k == 1 || k == 5 || k == 9));
      if (k == 3) begin
        chk("t4_rd0", bif1.i_rdata, 16'hBEEF);
        n1_iaddr = 8'h51;
      end
      if (k == 7) begin
        chk("t4_rd1", bif1.i_rdata, 16'h0F0F);
        n1_iaddr = 8'h52;
      end
      if (k == 11) begin
        chk("t4_rd2", bif1.i_rdata, 16'hC001);
        n1_ireq = 0;
      end
    end

    // load from 0x10
    n_dreq = 1; n_dwe = 0; n_daddr = 8'h10;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t1_mem_en", bif.mem_en, k == 1);
      chk("t1_stall", bif.stall, k < 4);
      chk("t1_d_ack", bif.d_ack, k == 4);
      if (k == 1) chk("t1_addr", bif.mem_addr, 8'h10);
      if (k == 4) begin
        chk("t1_d_rdata", bif.d_rdata, 8'hA5);
        n_dreq = 0;
      end
    end

    // simultaneous fetch and load
    n_ireq = 1; n_iaddr = 8'h30;
    n_dreq = 1; n_daddr = 8'h11;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("t2_d_ack", bif.d_ack, k == 4);
      chk("t2_i_ack", bif.i_ack, k == 9);
      chk("t2_mem_en", bif.mem_en, (k == 1 || k == 6));
      if (k == 4) begin
        chk("t2_d_rdata", bif.d_rdata, 8'h77);
        n_dreq = 0;
      end
      if (k == 9) begin
        chk("t2_i_rdata", bif.i_rdata, 16'h1234);
        n_ireq = 0;
      end
    end

    // store 0x3C to 0x20
    n_dreq = 1; n_dwe = 1; n_daddr = 8'h20;
    n_dwdata = 8'h3C;
    for (int k = 0; k < 5; k++) begin
      step();
      if (k == 1) begin
        chk("t3_mem_en", bif.mem_en, 1);
        chk("t3_mem_we", bif.mem_we, 1);
        chk("t3_addr", bif.mem_addr, 8'h20);
        chk("t3_wdata", bif.mem_wdata, 8'h3C);
      end
      chk("t3_d_ack", bif.d_ack, k == 4);
      if (k == 4) begin
        chk("t3_d_rdata", bif.d_rdata, 8'h77);
        n_dreq = 0; n_dwe = 0;
      end
    end

    // counter saturation and clear
    n_clr = 1;
    step();
    n_clr = 0;
    step();
    chk("t5_cnt0", bif.stall_cnt, 0);
    n_ireq = 1; n_iaddr = 8'h60;
    for (int k = 0; k < 30; k++) begin
      step();
      if (k == 24) chk("t5_sat", bif.stall_cnt, 15);
      if (k == 25) chk("t5_hold", bif.stall_cnt, 15);
      if (k == 26) chk("t5_clr", bif.stall_cnt, 0);
      n_clr = (k == 24);
      if (k == 29) n_ireq = 0;
    end

    // reset during a load
    n_dreq = 1; n_dwe = 0; n_daddr = 8'h40;
    step();
    step();
    n_reset = 0; n_dreq = 0;
    step();
    chk("t6_mem_en", bif.mem_en, 0);
    chk("t6_d_ack", bif.d_ack, 0);
    chk("t6_cnt", bif.stall_cnt, 0);
    chk("t6_i_rdata", bif.i_rdata, 0);
    chk("t6_d_rdata", bif.d_rdata, 0);
    n_reset = 1;
    for (int k = 3; k < 9; k++) begin
      step();
      chk("t6_no_ack", bif.d_ack, 0);
    end
    n_dreq = 1; n_daddr = 8'h41;
    for (int k = 9; k < 14; k++) begin
      step();
      chk("t6_re_ack", bif.d_ack, k == 13);
      if (k == 13) begin
        chk("t6_rdata", bif.d_rdata, 8'h66);
        n_dreq = 0;
      end
    end

    rnd = 1;
    repeat (4000) step();
    rnd = 0;

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
